// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants, pipeline tag type and arithmetic helpers for the
// multi-channel convolution core (cnn_core_mc) and its line/window sub-block.
package cnn_pkg;

    localparam int DEF_IMG_W = 28;
    localparam int DEF_IMG_H = 28;
    localparam int DEF_CI    = 2;
    localparam int DEF_CO    = 3;
    localparam int DEF_K     = 3;
    localparam int DEF_I_BW  = 8;
    localparam int DEF_W_BW  = 8;
    localparam int DEF_B_BW  = 16;
    localparam int DEF_O_BW  = 16;

    // Valid bit plus end-of-frame marker travelling alongside each pipeline stage.
    typedef struct packed {
        logic valid;
        logic last;
    } stage_tag_t;

    // Width that holds a full sum of taps products without overflow:
    // unsigned pixel * signed weight needs i_bw+w_bw+1 bits, the tree adds log2(taps).
    function automatic int acc_width(input int i_bw, input int w_bw, input int taps);
        return i_bw + w_bw + 1 + $clog2(taps);
    endfunction

    // Clamp a sign-extended value into the signed range of an o_bw-bit result.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int o_bw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (o_bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (o_bw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/cnn_core_mc_if.sv
// cnn_core_mc_if: pixel stream in, convolution result stream out, plus the
// frame-stable weight and bias buses. The master side is the pixel source.
interface cnn_core_mc_if #(
    parameter int CI   = 2,
    parameter int CO   = 3,
    parameter int K    = 3,
    parameter int I_BW = 8,
    parameter int W_BW = 8,
    parameter int B_BW = 16,
    parameter int O_BW = 16
);
    logic [CO*CI*K*K*W_BW-1:0] i_cnn_weight;
    logic [CO*B_BW-1:0]        i_cnn_bias;
    logic                      i_in_valid;
    logic [CI*I_BW-1:0]        i_in_fmap;
    logic                      i_frame_start;
    logic                      o_ot_valid;
    logic [CO*O_BW-1:0]        o_ot_fmap;
    logic                      o_frame_done;

    modport master (
        output i_cnn_weight, i_cnn_bias, i_in_valid, i_in_fmap, i_frame_start,
        input  o_ot_valid, o_ot_fmap, o_frame_done
    );

    modport slave (
        input  i_cnn_weight, i_cnn_bias, i_in_valid, i_in_fmap, i_frame_start,
        output o_ot_valid, o_ot_fmap, o_frame_done
    );
endinterface

// File: rtl/cnn_line_window.sv
// cnn_line_window: one input channel's K-1 row line buffer and KxK window.
// On every accepted pixel the window shifts left by one column; the new right
// column is the K-1 buffered pixels above the current position plus the pixel
// itself. The window is meaningful once row >= K-1 and col >= K-1.
// Storage is never cleared: stale contents are always overwritten before use.
module cnn_line_window #(
    parameter int IMG_W = 28,
    parameter int K     = 3,
    parameter int I_BW  = 8,
    parameter int COL_W = 5
) (
    input  logic                  clk,
    input  logic                  load,
    input  logic [COL_W-1:0]      col,
    input  logic [I_BW-1:0]       pixel,
    output logic [K*K*I_BW-1:0]   window
);
    // line_mem[j][c] holds row (current_row - (K-1) + j) at column c.
    logic [I_BW-1:0] line_mem [K-1][IMG_W];
    logic [I_BW-1:0] win      [K][K];

    // Shift the column history up one row at this column and load the new pixel.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int j = 0; j < K - 2; j++) begin
                line_mem[j][col] <= line_mem[j+1][col];
            end
            line_mem[K-2][col] <= pixel;
        end
    end

    // Slide the window left and insert the freshly assembled right-hand column.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K - 1; kx++) begin
                    win[ky][kx] <= win[ky][kx+1];
                end
            end
            for (int ky = 0; ky < K - 1; ky++) begin
                win[ky][K-1] <= line_mem[ky][col];
            end
            win[K-1][K-1] <= pixel;
        end
    end

    // Flatten the window as tap index ky*K+kx.
    always_comb begin
        window = '0;
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
                window[(ky*K+kx)*I_BW +: I_BW] = win[ky][kx];
            end
        end
    end

endmodule

// File: rtl/cnn_core_mc.sv
// cnn_core_mc: streaming multi-channel KxK convolution (stride 1, no padding).
// Window register, then three pipeline stages: multiply, adder tree,
// bias + optional ReLU + saturate. A result appears 3 cycles after the edge
// that accepted the pixel completing its window, whatever the input gaps.
// Build option: define CNN_CORE_RELU_EN to force negative sums to zero
// before saturation; left undefined the signed sum saturates as is.
module cnn_core_mc
    import cnn_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int CI    = DEF_CI,
    parameter int CO    = DEF_CO,
    parameter int K     = DEF_K,
    parameter int I_BW  = DEF_I_BW,
    parameter int W_BW  = DEF_W_BW,
    parameter int B_BW  = DEF_B_BW,
    parameter int O_BW  = DEF_O_BW
) (
    input  logic         clk,
    input  logic         reset,
    cnn_core_mc_if.slave bus
);
    localparam int TAPS   = CI * K * K;
    localparam int PROD_W = I_BW + W_BW + 1;
    localparam int ACC_W  = acc_width(I_BW, W_BW, TAPS);
    localparam int SUM_W  = ((ACC_W > B_BW) ? ACC_W : B_BW) + 1;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);

    logic [COL_W-1:0] col_q, cur_col, nxt_col;
    logic [ROW_W-1:0] row_q, cur_row, nxt_row;
    logic             win_done;
    logic             frame_end;

    stage_tag_t s0, s1, s2;

    logic [K*K*I_BW-1:0]     win_flat [CI];
    logic signed [PROD_W-1:0] prod_d  [CO][TAPS];
    logic signed [PROD_W-1:0] prod_q  [CO][TAPS];
    logic signed [ACC_W-1:0]  acc_d   [CO];
    logic signed [ACC_W-1:0]  acc_q   [CO];
    logic [CO*O_BW-1:0]       out_d;

    logic               ot_valid;
    logic [CO*O_BW-1:0] ot_fmap;
    logic               frame_done;

    // Position of the pixel on the bus; a frame start snaps it to (0,0).
    always_comb begin
        cur_col = bus.i_frame_start ? '0 : col_q;
        cur_row = bus.i_frame_start ? '0 : row_q;
        nxt_col = cur_col + 1'b1;
        nxt_row = cur_row;
        if (cur_col == COL_W'(IMG_W - 1)) begin
            nxt_col = '0;
            nxt_row = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
        end
        win_done  = (cur_row >= ROW_W'(K - 1)) && (cur_col >= COL_W'(K - 1));
        frame_end = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));
    end

    // Raster counters advance once per accepted pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (bus.i_in_valid) begin
            col_q <= nxt_col;
            row_q <= nxt_row;
        end
    end

    for (genvar ci = 0; ci < CI; ci++) begin : g_win
        cnn_line_window #(
            .IMG_W (IMG_W),
            .K     (K),
            .I_BW  (I_BW),
            .COL_W (COL_W)
        ) u_win (
            .clk    (clk),
            .load   (bus.i_in_valid),
            .col    (cur_col),
            .pixel  (bus.i_in_fmap[ci*I_BW +: I_BW]),
            .window (win_flat[ci])
        );
    end

    // Valid/last tags: s0 marks a complete window, s1..s2 follow the data stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0 <= '0;
            s1 <= '0;
            s2 <= '0;
        end else begin
            s0.valid <= bus.i_in_valid && win_done;
            if (bus.i_in_valid && win_done) s0.last <= frame_end;
            s1.valid <= s0.valid;
            if (s0.valid) s1.last <= s0.last;
            s2.valid <= s1.valid;
            if (s1.valid) s2.last <= s1.last;
        end
    end

    // Stage 1 operands: zero-extended pixel times sign-extended weight.
    always_comb begin
        logic [I_BW-1:0]          praw;
        logic [W_BW-1:0]          wraw;
        logic signed [PROD_W-1:0] px;
        logic signed [PROD_W-1:0] wt;
        praw   = '0;
        wraw   = '0;
        px     = '0;
        wt     = '0;
        prod_d = '{default: '0};
        for (int co = 0; co < CO; co++) begin
            for (int ci = 0; ci < CI; ci++) begin
                for (int t = 0; t < K*K; t++) begin
                    praw = win_flat[ci][t*I_BW +: I_BW];
                    wraw = bus.i_cnn_weight[(co*TAPS + ci*K*K + t)*W_BW +: W_BW];
                    px   = {{(PROD_W-I_BW){1'b0}}, praw};
                    wt   = {{(PROD_W-W_BW){wraw[W_BW-1]}}, wraw};
                    prod_d[co][ci*K*K + t] = px * wt;
                end
            end
        end
    end

    // Stage 1 register: products of the window captured by s0.
    always_ff @(posedge clk) begin
        if (s0.valid) prod_q <= prod_d;
    end

    // Stage 2 operands: full-width sum of all taps per output channel.
    always_comb begin
        acc_d = '{default: '0};
        for (int co = 0; co < CO; co++) begin
            for (int t = 0; t < TAPS; t++) begin
                acc_d[co] = acc_d[co]
                          + {{(ACC_W-PROD_W){prod_q[co][t][PROD_W-1]}}, prod_q[co][t]};
            end
        end
    end

    // Stage 2 register: per-channel tap sums.
    always_ff @(posedge clk) begin
        if (s1.valid) acc_q <= acc_d;
    end

    // Stage 3 operands: add bias, optional ReLU, clamp to the output range.
    always_comb begin
        logic signed [SUM_W-1:0] sum;
        logic [B_BW-1:0]         b;
        sum   = '0;
        b     = '0;
        out_d = '0;
        for (int co = 0; co < CO; co++) begin
            b   = bus.i_cnn_bias[co*B_BW +: B_BW];
            sum = {{(SUM_W-ACC_W){acc_q[co][ACC_W-1]}}, acc_q[co]}
                + {{(SUM_W-B_BW){b[B_BW-1]}}, b};
`ifdef CNN_CORE_RELU_EN
            if (sum[SUM_W-1]) sum = '0;
`endif
            out_d[co*O_BW +: O_BW] = O_BW'(saturate({{(64-SUM_W){sum[SUM_W-1]}}, sum}, O_BW));
        end
    end

    // Stage 3 register: result, its valid, and the end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            ot_valid   <= 1'b0;
            ot_fmap    <= '0;
            frame_done <= 1'b0;
        end else begin
            ot_valid   <= s2.valid;
            frame_done <= s2.valid && s2.last;
            if (s2.valid) ot_fmap <= out_d;
        end
    end

    assign bus.o_ot_valid   = ot_valid;
    assign bus.o_ot_fmap    = ot_fmap;
    assign bus.o_frame_done = frame_done;

endmodule

// File: tb/tb_cnn_core_mc.sv
// tb_cnn_core_mc: 5x5 frames, K=3, CI=2, CO=2. A direct convolution model over
// a stored image predicts every output and the edge it must appear on; a
// negedge process compares the DUT against it every cycle. Literal cases pin
// the model. Honours CNN_CORE_RELU_EN like the design.
module tb_cnn_core_mc;
    localparam int IMG_W = 5, IMG_H = 5, CI = 2, CO = 2, K = 3;
    localparam int I_BW = 8, W_BW = 8, B_BW = 16, O_BW = 16;
    localparam int NOUT = (IMG_W-K+1)*(IMG_H-K+1);
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cnn_core_mc_if #(.CI(CI), .CO(CO), .K(K), .I_BW(I_BW), .W_BW(W_BW),
                     .B_BW(B_BW), .O_BW(O_BW)) bus ();

    cnn_core_mc #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CI(CI), .CO(CO), .K(K),
                  .I_BW(I_BW), .W_BW(W_BW), .B_BW(B_BW), .O_BW(O_BW))
        dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [31:0]        due;
        logic               done;
        logic [CO*O_BW-1:0] fmap;
    } exp_t;

    exp_t q[$];
    exp_t cur_e;

    int w_arr [CO][CI][K][K];
    int b_arr [CO];
    int img   [CI][IMG_H][IMG_W];
    int m_row, m_col;
    logic [CO*O_BW-1:0] m_last;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    logic in_reset = 1'b1;

    int n_dut_out, n_dut_done, first_out_edge, first_cplt_edge, done_edge, last_out_edge;
    logic [CO*O_BW-1:0] last_fmap;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic clear_stats();
        n_dut_out = 0; n_dut_done = 0;
        first_out_edge = -1; first_cplt_edge = -1; done_edge = -1; last_out_edge = -1;
        last_fmap = '0;
    endtask

    task automatic apply_cfg();
        for (int co = 0; co < CO; co++) begin
            for (int ci = 0; ci < CI; ci++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        bus.i_cnn_weight[((co*CI+ci)*K*K+ky*K+kx)*W_BW +: W_BW] = W_BW'(w_arr[co][ci][ky][kx]);
            bus.i_cnn_bias[co*B_BW +: B_BW] = B_BW'(b_arr[co]);
        end
    endtask

    // Reference: store the pixel, and if it completes a window, convolve directly.
    task automatic model_accept(input logic [CI*I_BW-1:0] pv, input logic fs, input int acc_edge);
        exp_t e;
        int s;
        if (fs) begin m_row = 0; m_col = 0; end
        for (int ci = 0; ci < CI; ci++) img[ci][m_row][m_col] = int'(pv[ci*I_BW +: I_BW]);
        if (m_row >= K-1 && m_col >= K-1) begin
            if (first_cplt_edge < 0) first_cplt_edge = acc_edge;
            e.due  = 32'(acc_edge + LAT);
            e.done = (m_row == IMG_H-1) && (m_col == IMG_W-1);
            e.fmap = '0;
            for (int co = 0; co < CO; co++) begin
                s = b_arr[co];
                for (int ci = 0; ci < CI; ci++)
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++)
                            s += w_arr[co][ci][ky][kx] * img[ci][m_row-K+1+ky][m_col-K+1+kx];
`ifdef CNN_CORE_RELU_EN
                if (s < 0) s = 0;
`endif
                if (s > (1 << (O_BW-1)) - 1) s = (1 << (O_BW-1)) - 1;
                if (s < -(1 << (O_BW-1))) s = -(1 << (O_BW-1));
                e.fmap[co*O_BW +: O_BW] = O_BW'(s);
            end
            m_last = e.fmap;
            q.push_back(e);
        end
        m_col++;
        if (m_col == IMG_W) begin
            m_col = 0;
            m_row = (m_row == IMG_H-1) ? 0 : m_row + 1;
        end
    endtask

    // Called 1ns after a rising edge; the pixel is accepted on the next edge.
    task automatic drive_pixel(input logic [CI*I_BW-1:0] pv, input logic fs, input int gap);
        bus.i_in_valid = 1'b1;
        bus.i_in_fmap = pv;
        bus.i_frame_start = fs;
        model_accept(pv, fs, edge_cnt + 1);
        @(posedge clk); #1;
        bus.i_in_valid = 1'b0;
        bus.i_frame_start = 1'b0;
        bus.i_in_fmap = CI*I_BW'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // mode 0: every pixel = pval; mode 1: random pixels. gap < 0: random 0..2.
    task automatic run_pixels(input int n, input int mode, input int pval, input int gap, input logic use_fs);
        logic [CI*I_BW-1:0] pv;
        for (int i = 0; i < n; i++) begin
            for (int ci = 0; ci < CI; ci++)
                pv[ci*I_BW +: I_BW] = (mode == 0) ? I_BW'(pval) : I_BW'($urandom_range(0, 255));
            drive_pixel(pv, use_fs && (i == 0), (gap < 0) ? int'($urandom_range(0, 2)) : gap);
        end
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        reset = 1'b1;
        bus.i_in_valid = 1'b0;
        bus.i_frame_start = 1'b0;
        @(posedge clk); #1;
        chk("rst_valid", 64'(bus.o_ot_valid), 64'd0);
        chk("rst_fmap", 64'(bus.o_ot_fmap), 64'd0);
        chk("rst_done", 64'(bus.o_frame_done), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        m_row = 0; m_col = 0;
        in_reset = 1'b0;
    endtask

    task automatic set_const_cfg(input int wv, input int bv);
        for (int co = 0; co < CO; co++) begin
            for (int ci = 0; ci < CI; ci++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++) w_arr[co][ci][ky][kx] = wv;
            b_arr[co] = bv;
        end
        apply_cfg();
    endtask

    task automatic const_case(input string name, input int pval, input int wv, input int bv,
                              input int gap, input logic fs, input int lit);
        logic [O_BW-1:0] l;
        l = O_BW'(lit);
        set_const_cfg(wv, bv);
        clear_stats();
        run_pixels(IMG_W*IMG_H, 0, pval, gap, fs);
        drain(6);
        chk({name, "_outs"}, 64'(n_dut_out), 64'(NOUT));
        chk({name, "_done_cnt"}, 64'(n_dut_done), 64'd1);
        chk({name, "_done_pos"}, 64'(done_edge), 64'(last_out_edge));
        chk({name, "_lat"}, 64'(first_out_edge - first_cplt_edge), 64'(LAT));
        chk({name, "_ch0"}, 64'(last_fmap[O_BW-1:0]), 64'(l));
        chk({name, "_ch1"}, 64'(last_fmap[O_BW +: O_BW]), 64'(l));
        chk({name, "_model"}, 64'(m_last[O_BW-1:0]), 64'(l));
    endtask

    // Per-cycle comparison against the model, plus DUT-side statistics.
    initial begin
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                if (bus.o_ot_valid) begin
                    n_dut_out++;
                    last_fmap = bus.o_ot_fmap;
                    last_out_edge = edge_cnt;
                    if (first_out_edge < 0) first_out_edge = edge_cnt;
                end
                if (bus.o_frame_done) begin
                    n_dut_done++;
                    done_edge = edge_cnt;
                end
                if (q.size() > 0 && int'(q[0].due) < edge_cnt) begin
                    cur_e = q.pop_front();
                    chk("missed_output", 64'(edge_cnt), 64'(cur_e.due));
                end
                if (q.size() > 0 && int'(q[0].due) == edge_cnt) begin
                    cur_e = q.pop_front();
                    chk("valid", 64'(bus.o_ot_valid), 64'd1);
                    chk("fmap", 64'(bus.o_ot_fmap), 64'(cur_e.fmap));
                    chk("done", 64'(bus.o_frame_done), 64'(cur_e.done));
                end else begin
                    chk("idle_valid", 64'(bus.o_ot_valid), 64'd0);
                    chk("idle_done", 64'(bus.o_frame_done), 64'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.i_in_valid = 1'b0;
        bus.i_in_fmap = '0;
        bus.i_frame_start = 1'b0;
        bus.i_cnn_weight = '0;
        bus.i_cnn_bias = '0;
        m_row = 0; m_col = 0;
        clear_stats();
        @(posedge clk); #1;
        do_reset();

        const_case("ones", 1, 1, 0, 0, 1'b1, 18);
        const_case("bias5", 1, 1, 5, 0, 1'b1, 23);
`ifdef CNN_CORE_RELU_EN
        const_case("neg", 1, -1, 0, 0, 1'b1, 0);
`else
        const_case("neg", 1, -1, 0, 0, 1'b1, -18);
`endif
        const_case("sat", 255, 127, 0, 0, 1'b1, 32767);
        const_case("gap", 1, 1, 0, 1, 1'b1, 18);

        // Reset mid-frame; second pass also relies on counters returning to (0,0).
        for (int n = 12; n <= 13; n++) begin
            set_const_cfg(1, 0);
            run_pixels(n, 0, 1, 0, 1'b1);
            do_reset();
            const_case((n == 12) ? "rst12" : "rst13", 1, 1, 0, 0, n == 12, 18);
        end

        // Random frames: random weights/bias/pixels/gaps, back-to-back and restarted frames.
        for (int f = 0; f < 6; f++) begin
            if (f != 2) begin
                drain(6);
                for (int co = 0; co < CO; co++) begin
                    for (int ci = 0; ci < CI; ci++)
                        for (int ky = 0; ky < K; ky++)
                            for (int kx = 0; kx < K; kx++)
                                w_arr[co][ci][ky][kx] = int'($urandom_range(0, 255)) - 128;
                    b_arr[co] = (f == 4) ? int'($urandom_range(0, 65535)) - 32768
                                         : int'($urandom_range(0, 2000)) - 1000;
                end
                apply_cfg();
            end
            if (f == 3) run_pixels(8, 1, 0, -1, 1'b1);
            run_pixels(IMG_W*IMG_H, 1, 0, -1, (f % 2) == 0 || f == 3);
        end

        drain(8);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
